taxi_axil_reg_slave: RTL and testbench

AXI-Lite slave endpoint that terminates the taxi_axil_if write/read channels into a bank of NUM_REGS DATA_W-bit control/status registers. It sits directly downstream of an AXI-Lite master or register slice and consumes the wr_slv/rd_slv channel signals. Registers marked read-only reflect hardware inputs. Registers marked writable drive fabric outputs and emit per-register write pulses.

---
 rtl/taxi_axil_pkg.sv | 21 ++
 rtl/taxi_axil_reg_slave.sv | 193 +++++++++++++++++++
 tb/tb_taxi_axil_reg_slave.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/taxi_axil_pkg.sv
// Shared AXI-Lite response codes and channel FSM state encodings for the register slave.
package taxi_axil_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } wr_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_t;

endpackage

// File: rtl/taxi_axil_reg_slave.sv
// AXI-Lite slave terminating into NUM_REGS control/status registers; write response and read data
// arrive one cycle after commit / AR handshake and are held stable until the master accepts them.
module taxi_axil_reg_slave
  import taxi_axil_pkg::*;
#(
  parameter int                   DATA_W    = 32,
  parameter int                   ADDR_W    = 8,
  parameter int                   STRB_W    = DATA_W / 8,
  parameter int                   NUM_REGS  = 16,
  parameter logic [NUM_REGS-1:0]  RO_MASK   = '0,
  parameter logic [DATA_W-1:0]    RESET_VAL = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ADDR_W-1:0]            s_axil_awaddr,
  input  logic [2:0]                   s_axil_awprot,
  input  logic                         s_axil_awvalid,
  output logic                         s_axil_awready,
  input  logic [DATA_W-1:0]            s_axil_wdata,
  input  logic [STRB_W-1:0]            s_axil_wstrb,
  input  logic                         s_axil_wvalid,
  output logic                         s_axil_wready,
  output logic [1:0]                   s_axil_bresp,
  output logic                         s_axil_bvalid,
  input  logic                         s_axil_bready,
  input  logic [ADDR_W-1:0]            s_axil_araddr,
  input  logic [2:0]                   s_axil_arprot,
  input  logic                         s_axil_arvalid,
  output logic                         s_axil_arready,
  output logic [DATA_W-1:0]            s_axil_rdata,
  output logic [1:0]                   s_axil_rresp,
  output logic                         s_axil_rvalid,
  input  logic                         s_axil_rready,
  output logic                         s_axil_buser,
  output logic                         s_axil_ruser,
  input  logic [NUM_REGS*DATA_W-1:0]   ro_in,
  output logic [NUM_REGS*DATA_W-1:0]   reg_out,
  output logic [NUM_REGS-1:0]          wr_pulse
);

  localparam int LSB   = $clog2(STRB_W);
  localparam int IDX_W = ADDR_W - LSB;

  wr_state_t             wr_state_q, wr_state_d;
  rd_state_t             rd_state_q, rd_state_d;
  logic                  aw_held_q, w_held_q;
  logic [ADDR_W-1:0]     awaddr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [STRB_W-1:0]     wstrb_q;
  logic                  bvalid_q, rvalid_q;
  resp_t                 bresp_q, rresp_q;
  logic [DATA_W-1:0]     rdata_q;
  logic [NUM_REGS-1:0]   wr_pulse_q;
  logic [DATA_W-1:0]     regs_q [NUM_REGS];

  logic                  aw_hs, w_hs, ar_hs, commit;
  logic [ADDR_W-1:0]     wr_addr;
  logic [DATA_W-1:0]     wr_data;
  logic [STRB_W-1:0]     wr_strb;
  logic [IDX_W-1:0]      wr_idx, rd_idx;
  logic [NUM_REGS-1:0]   wr_hit;
  resp_t                 wr_resp, rd_resp;
  logic [DATA_W-1:0]     rd_val;

  // Ready is a pure function of state and held flags, so handshakes are derived without a comb loop.
  assign aw_hs   = (wr_state_q == W_IDLE) && !aw_held_q && s_axil_awvalid;
  assign w_hs    = (wr_state_q == W_IDLE) && !w_held_q && s_axil_wvalid;
  assign commit  = (wr_state_q == W_IDLE) && (aw_held_q || s_axil_awvalid) && (w_held_q || s_axil_wvalid);
  assign ar_hs   = (rd_state_q == R_IDLE) && s_axil_arvalid;

  assign wr_addr = aw_held_q ? awaddr_q : s_axil_awaddr;
  assign wr_data = w_held_q ? wdata_q : s_axil_wdata;
  assign wr_strb = w_held_q ? wstrb_q : s_axil_wstrb;
  assign wr_idx  = wr_addr[ADDR_W-1:LSB];
  assign rd_idx  = s_axil_araddr[ADDR_W-1:LSB];

  always_comb begin
    wr_hit  = '0;
    wr_resp = DECERR;
    rd_val  = '0;
    rd_resp = DECERR;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wr_idx == IDX_W'(i)) begin
        wr_resp   = RO_MASK[i] ? SLVERR : OKAY;
        wr_hit[i] = !RO_MASK[i];
      end
      if (rd_idx == IDX_W'(i)) begin
        rd_resp = OKAY;
        rd_val  = RO_MASK[i] ? ro_in[i*DATA_W +: DATA_W] : regs_q[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_state_q <= W_IDLE;
      rd_state_q <= R_IDLE;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
    end
  end

  always_comb begin
    wr_state_d     = wr_state_q;
    s_axil_awready = 1'b0;
    s_axil_wready  = 1'b0;
    case (wr_state_q)
      W_IDLE: begin
        s_axil_awready = !aw_held_q;
        s_axil_wready  = !w_held_q;
        if (commit) wr_state_d = W_RESP;
      end
      W_RESP: if (s_axil_bready) wr_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    rd_state_d     = rd_state_q;
    s_axil_arready = 1'b0;
    case (rd_state_q)
      R_IDLE: begin
        s_axil_arready = 1'b1;
        if (s_axil_arvalid) rd_state_d = R_DATA;
      end
      R_DATA: if (s_axil_rready) rd_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= OKAY;
      wr_pulse_q <= '0;
      rvalid_q   <= 1'b0;
      rresp_q    <= OKAY;
      rdata_q    <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RO_MASK[i] ? '0 : RESET_VAL;
    end else begin
      wr_pulse_q <= '0;
      if (commit) begin
        aw_held_q  <= 1'b0;
        w_held_q   <= 1'b0;
        bvalid_q   <= 1'b1;
        bresp_q    <= wr_resp;
        wr_pulse_q <= wr_hit;
      end else begin
        if (aw_hs) begin
          aw_held_q <= 1'b1;
          awaddr_q  <= s_axil_awaddr;
        end
        if (w_hs) begin
          w_held_q <= 1'b1;
          wdata_q  <= s_axil_wdata;
          wstrb_q  <= s_axil_wstrb;
        end
        if (bvalid_q && s_axil_bready) bvalid_q <= 1'b0;
      end
      for (int i = 0; i < NUM_REGS; i++)
        for (int b = 0; b < STRB_W; b++)
          if (commit && wr_hit[i] && wr_strb[b]) regs_q[i][8*b +: 8] <= wr_data[8*b +: 8];
      if (ar_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_val;
        rresp_q  <= rd_resp;
      end else if (rvalid_q && s_axil_rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
    assign reg_out[g*DATA_W +: DATA_W] = RO_MASK[g] ? '0 : regs_q[g];
  end

  assign s_axil_bvalid = bvalid_q;
  assign s_axil_bresp  = bresp_q;
  assign s_axil_rvalid = rvalid_q;
  assign s_axil_rresp  = rresp_q;
  assign s_axil_rdata  = rdata_q;
  assign s_axil_buser  = 1'b0;
  assign s_axil_ruser  = 1'b0;
  assign wr_pulse      = wr_pulse_q;

  logic unused_ok;
  assign unused_ok = ^{s_axil_awprot, s_axil_arprot, wr_addr[LSB-1:0], s_axil_araddr[LSB-1:0], ro_in};

endmodule

// File: tb/tb_taxi_axil_reg_slave.sv
module tb_taxi_axil_reg_slave;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   awaddr, araddr;
  logic [2:0]   awprot = 3'b0, arprot = 3'b0;
  logic         awvalid, awready, wvalid, wready, bvalid, bready;
  logic [31:0]  wdata, rdata;
  logic [3:0]   wstrb;
  logic [1:0]   bresp, rresp;
  logic         arvalid, arready, rvalid, rready, buser, ruser;
  logic [511:0] ro_in, reg_out;
  logic [15:0]  wr_pulse;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  taxi_axil_reg_slave #(
    .DATA_W(32), .ADDR_W(8), .NUM_REGS(16), .RO_MASK(16'h0008), .RESET_VAL(32'h0)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axil_awaddr(awaddr), .s_axil_awprot(awprot), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
    .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
    .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
    .s_axil_araddr(araddr), .s_axil_arprot(arprot), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
    .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready),
    .s_axil_buser(buser), .s_axil_ruser(ruser),
    .ro_in(ro_in), .reg_out(reg_out), .wr_pulse(wr_pulse)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // AW and W presented together; returns response and the pulse seen with bvalid.
  task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] resp, output logic [15:0] pulse);
    int n = 0;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    while (!(awready && wready) && n < 20) begin step(); n++; end
    if (n >= 20) check("wr_ready_timeout", 64'd0, 64'd1);
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    check("bvalid_latency", {63'd0, bvalid}, 64'd1);
    resp = bresp; pulse = wr_pulse;
    bready = 1'b1;
    step();
    bready = 1'b0;
    check("wr_pulse_one_cycle", {48'd0, wr_pulse}, 64'd0);
    check("bvalid_drop", {63'd0, bvalid}, 64'd0);
  endtask

  task automatic do_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n = 0;
    araddr = a; arvalid = 1'b1; rready = 1'b0;
    while (!arready && n < 20) begin step(); n++; end
    if (n >= 20) check("rd_ready_timeout", 64'd0, 64'd1);
    step();
    arvalid = 1'b0;
    check("rvalid_latency", {63'd0, rvalid}, 64'd1);
    d = rdata; resp = rresp;
    rready = 1'b1;
    step();
    rready = 1'b0;
  endtask

  typedef struct {
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic [31:0] exp;
    logic [15:0] pulse;
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic [1:0]   r;
    logic [15:0]  p;
    logic [31:0]  d;
    logic [511:0] snap;
    int           idx;
    bit           stable;

    vecs[0]  = '{1'b1, 8'h04, 32'hDEADBEEF, 4'hF, 2'b00, 32'hDEADBEEF, 16'h0002};
    vecs[1]  = '{1'b0, 8'h04, 32'h0,        4'h0, 2'b00, 32'hDEADBEEF, 16'h0000};
    vecs[2]  = '{1'b1, 8'h0C, 32'h12345678, 4'hF, 2'b10, 32'h0,        16'h0000};
    vecs[3]  = '{1'b0, 8'h0C, 32'h0,        4'h0, 2'b00, 32'hCAFEF00D, 16'h0000};
    vecs[4]  = '{1'b1, 8'h40, 32'h55555555, 4'hF, 2'b11, 32'h0,        16'h0000};
    vecs[5]  = '{1'b0, 8'h40, 32'h0,        4'h0, 2'b11, 32'h0,        16'h0000};
    vecs[6]  = '{1'b1, 8'h06, 32'hAABBCCDD, 4'h8, 2'b00, 32'hAAADBEEF, 16'h0002};
    vecs[7]  = '{1'b0, 8'h07, 32'h0,        4'h0, 2'b00, 32'hAAADBEEF, 16'h0000};
    vecs[8]  = '{1'b1, 8'h3C, 32'hFFFFFFFF, 4'h0, 2'b00, 32'h0,        16'h8000};
    vecs[9]  = '{1'b0, 8'h3C, 32'h0,        4'h0, 2'b00, 32'h0,        16'h0000};
    vecs[10] = '{1'b1, 8'h3C, 32'h01020304, 4'hF, 2'b00, 32'h01020304, 16'h8000};
    vecs[11] = '{1'b0, 8'h3C, 32'h0,        4'h0, 2'b00, 32'h01020304, 16'h0000};

    ro_in = '0;
    ro_in[3*32 +: 32] = 32'hCAFEF00D;
    awaddr = '0; wdata = '0; wstrb = '0; awvalid = 0; wvalid = 0; bready = 0;
    araddr = '0; arvalid = 0; rready = 0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    step();

    check("rst_ready", {61'd0, awready, wready, arready}, 64'h7);
    check("rst_valid", {62'd0, bvalid, rvalid}, 64'h0);
    check("rst_reg_out", {63'd0, |reg_out}, 64'd0);
    check("rst_pulse_user", {46'd0, wr_pulse, buser, ruser}, 64'd0);

    for (int i = 0; i < 12; i++) begin
      if (vecs[i].wr) begin
        snap = reg_out;
        do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, r, p);
        check($sformatf("v%0d_bresp", i), {62'd0, r}, {62'd0, vecs[i].resp});
        check($sformatf("v%0d_pulse", i), {48'd0, p}, {48'd0, vecs[i].pulse});
        idx = int'(vecs[i].addr[7:2]);
        if (vecs[i].resp != 2'b00) check($sformatf("v%0d_no_change", i), {63'd0, reg_out != snap}, 64'd0);
        else check($sformatf("v%0d_reg", i), {32'd0, reg_out[idx*32 +: 32]}, {32'd0, vecs[i].exp});
      end else begin
        do_read(vecs[i].addr, d, r);
        check($sformatf("v%0d_rresp", i), {62'd0, r}, {62'd0, vecs[i].resp});
        check($sformatf("v%0d_rdata", i), {32'd0, d}, {32'd0, vecs[i].exp});
      end
    end

    // W three cycles ahead of AW, then response held off by bready.
    wdata = 32'h11223344; wstrb = 4'b0101; wvalid = 1'b1; bready = 1'b0;
    step();
    wvalid = 1'b0;
    check("early_w_wready", {62'd0, wready, awready}, 64'h1);
    step(); step();
    check("early_w_no_bvalid", {63'd0, bvalid}, 64'd0);
    awaddr = 8'h08; awvalid = 1'b1;
    step();
    awvalid = 1'b0;
    check("late_aw_bvalid", {62'd0, bvalid, awready}, 64'h2);
    check("late_aw_pulse", {48'd0, wr_pulse}, 64'h0004);
    check("late_aw_reg2", {32'd0, reg_out[2*32 +: 32]}, 64'h00220044);
    stable = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      if (!(bvalid === 1'b1 && bresp === 2'b00 && awready === 1'b0 && wready === 1'b0)) stable = 1'b0;
    end
    check("bresp_stall_stable", {63'd0, stable}, 64'd1);
    bready = 1'b1;
    step();
    bready = 1'b0;
    check("stall_release", {61'd0, bvalid, awready, wready}, 64'h3);

    // Same-edge read and write of register 5 returns the old value.
    do_write(8'h14, 32'h0000000A, 4'hF, r, p);
    awaddr = 8'h14; wdata = 32'h0000000B; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 8'h14; arvalid = 1'b1; bready = 1'b1; rready = 1'b1;
    step();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    check("same_edge_rdata", {32'd0, rdata}, 64'h0000000A);
    step();
    bready = 1'b0; rready = 1'b0;
    do_read(8'h14, d, r);
    check("after_same_edge_rdata", {32'd0, d}, 64'h0000000B);

    // Reset with both responses pending.
    awaddr = 8'h00; wdata = 32'h77; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 8'h04; arvalid = 1'b1;
    step();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    check("pre_rst_valids", {62'd0, bvalid, rvalid}, 64'h3);
    rst = 1'b1;
    #1;
    check("mid_rst_valids", {62'd0, bvalid, rvalid}, 64'h0);
    check("mid_rst_ready", {61'd0, awready, wready, arready}, 64'h7);
    check("mid_rst_reg_out", {63'd0, |reg_out}, 64'd0);
    step();
    rst = 1'b0;
    step();
    check("post_rst_idle", {59'd0, bvalid, rvalid, awready, wready, arready}, 64'h7);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
